// File: rtl/fast_adder_ques1.sv
// Two-stage pipelined 64-bit add/subtract unit built on a three-level
// carry-lookahead tree (bit -> 4-bit group -> 4-group block -> top).
module fast_adder_ques1 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             operation,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  // The 4x4x4 lookahead hierarchy below spans exactly 64 bits.
  localparam int NG = WIDTH / 4;
  localparam int NB = NG / 4;

  typedef struct packed {
    logic [3:0] c;   // carry into each of the four positions
    logic       gg;  // group generate
    logic       pp;  // group propagate
  } la_t;

  // Flattened 4-wide lookahead: every carry is a two-level sum of products.
  function automatic la_t lookahead(input logic [3:0] g, input logic [3:0] p,
                                    input logic cin);
    la_t r;
    r.c[0] = cin;
    r.c[1] = g[0] | (p[0] & cin);
    r.c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    r.c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & cin);
    r.gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
    r.pp   = &p;
    return r;
  endfunction

  logic [WIDTH-1:0] a_q, b_q;
  logic             op_q;

  // NOTE: non-blocking assignments let both stages update from pre-edge
  // values, so stage 2 always sees the previous stage-1 contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= 1'b0;
    end else begin
      a_q  <= a;
      b_q  <= b;
      op_q <= operation;
    end
  end

  logic [WIDTH-1:0] bx, g, p, c, s;
  logic [NG-1:0]    grp_g, grp_p, grp_c;
  logic [NB-1:0]    blk_g, blk_p, blk_c;
  logic             cout;
  la_t              la;

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    la    = '0;
    grp_g = '0;
    grp_p = '0;
    grp_c = '0;
    blk_g = '0;
    blk_p = '0;
    c     = '0;
    bx    = b_q ^ {WIDTH{op_q}};
    g     = a_q & bx;
    p     = a_q ^ bx;

    // Upward pass: group, then block generate/propagate.
    for (int i = 0; i < NG; i++) begin
      la       = lookahead(g[4*i +: 4], p[4*i +: 4], 1'b0);
      grp_g[i] = la.gg;
      grp_p[i] = la.pp;
    end
    for (int j = 0; j < NB; j++) begin
      la       = lookahead(grp_g[4*j +: 4], grp_p[4*j +: 4], 1'b0);
      blk_g[j] = la.gg;
      blk_p[j] = la.pp;
    end

    // Top unit: carry into bit 0 is the subtract flag.
    la    = lookahead(blk_g, blk_p, op_q);
    blk_c = la.c;
    cout  = la.gg | (la.pp & op_q);

    // Downward pass: group carry-ins, then bit carries.
    for (int j = 0; j < NB; j++) begin
      la                = lookahead(grp_g[4*j +: 4], grp_p[4*j +: 4], blk_c[j]);
      grp_c[4*j +: 4]   = la.c;
    end
    for (int i = 0; i < NG; i++) begin
      la            = lookahead(g[4*i +: 4], p[4*i +: 4], grp_c[i]);
      c[4*i +: 4]   = la.c;
    end

    s = p ^ c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      sum   <= s;
      carry <= cout;
    end
  end

endmodule

// File: tb/tb_fast_adder_ques1.sv
// Scoreboard bench for fast_adder_ques1: a driver queues expected results
// with their due cycle, a monitor pops and compares after each rising edge.
module tb_fast_adder_ques1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] a = '0, b = '0;
  logic        operation = 1'b0;
  logic [63:0] sum;
  logic        carry;

  fast_adder_ques1 #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .operation(operation),
    .sum(sum), .carry(carry)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [63:0] s;
    logic        c;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: add is a 65-bit sum; subtract is the modular difference with
  // carry meaning "no borrow" (a >= b unsigned).
  function automatic logic [64:0] ref_model(input logic [63:0] x,
                                            input logic [63:0] y,
                                            input logic op);
    logic [63:0] d;
    if (!op) return {1'b0, x} + {1'b0, y};
    d = x - y;
    return {(x >= y), d};
  endfunction

  task automatic check(input exp_t e);
    vectors++;
    if (sum !== e.s || carry !== e.c) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got sum=%h carry=%b, want sum=%h carry=%b",
               e.tag, cyc, sum, carry, e.s, e.c);
    end
  endtask

  // Monitor: results are due a fixed number of edges after sampling.
  always @(posedge clk) begin
    #1;
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      exp_t m;
      m = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL %s: result due at cyc %0d never checked", m.tag, m.due);
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) check(exp_q.pop_front());
  end

  task automatic drive(input logic [63:0] x, input logic [63:0] y,
                       input logic op, input string tag);
    logic [64:0] r;
    @(negedge clk);
    rst       = 1'b0;
    a         = x;
    b         = y;
    operation = op;
    r         = ref_model(x, y, op);
    exp_q.push_back('{due: cyc + 2, s: r[63:0], c: r[64], tag: tag});
  endtask

  // One reset edge: in-flight results are discarded, outputs read zero on
  // that edge and the next (stage 1 was cleared).
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    a   = {$urandom, $urandom};
    b   = {$urandom, $urandom};
    while (exp_q.size() > 0 && exp_q[$].due >= cyc + 1) void'(exp_q.pop_back());
    exp_q.push_back('{due: cyc + 1, s: 64'd0, c: 1'b0, tag: tag});
    exp_q.push_back('{due: cyc + 2, s: 64'd0, c: 1'b0, tag: tag});
  endtask

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return '1;
      1:       return '0;
      2:       return 64'd1;
      3:       return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    do_reset("reset");
    do_reset("reset");

    repeat (4) drive(64'h111, 64'h010, 1'b1, "sub_held");
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, "add_full_carry");
    drive(64'h0, 64'h1, 1'b1, "borrow");
    drive(64'h0, 64'h0, 1'b1, "zero_minus_zero");
    drive(64'h5, 64'h3, 1'b0, "b2b_add");
    drive(64'h5, 64'h3, 1'b1, "b2b_sub");
    drive(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, "msb_add");
    drive(64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b1, "equal_sub");
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, "ones_plus_zero");

    // Reset while two operations are in flight.
    drive(64'hDEAD, 64'hBEEF, 1'b0, "pre_reset");
    drive(64'hDEAD, 64'hBEEF, 1'b1, "pre_reset");
    do_reset("mid_reset");
    drive(64'h7, 64'h9, 1'b1, "post_reset");
    drive(64'h7, 64'h9, 1'b0, "post_reset");

    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset("rand_reset");
      else drive(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)), "random");
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d results still pending, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fast_adder_ques1.md
FAST_ADDER_QUES1 -- requirements
Module: fast_adder_ques1

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter: WIDTH, default 64, operand and result width; the block SHALL be verified at 64 only.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: a  input  64  operand A, unsigned/two's-complement agnostic.
REQ-006 Port: b  input  64  operand B.
REQ-007 Port: operation  input  1  0 = add (A+B), 1 = subtract (A-B).
REQ-008 Port: sum  output  64  registered result, low 64 bits.
REQ-009 Port: carry  output  1  registered carry-out of the 64-bit addition.

Function
REQ-010 The block SHALL be a two-stage pipeline: stage 1 registers a, b and operation on each rising clk edge; stage 2 registers sum and carry computed from the stage-1 registers.
REQ-011 Latency SHALL be 2 clk edges: inputs sampled at edge N appear on sum/carry after edge N+1; throughput is one operation per cycle, with no handshake and no stall.
REQ-012 Add (operation=0): {carry,sum} SHALL equal A + B, a 65-bit result.
REQ-013 Subtract (operation=1): {carry,sum} SHALL equal A + ~B + 1, i.e. B is bitwise inverted and carry-in is 1.
REQ-014 In subtract mode, carry=1 SHALL mean no borrow (A >= B unsigned) and carry=0 SHALL mean borrow (A < B unsigned).
REQ-015 The combinational adder SHALL be a carry-lookahead structure, not a ripple chain:
  - 4-bit CLA groups with per-bit generate g=a&b' and propagate p=a^b', where b' is b XOR operation.
  - Group generate/propagate SHALL feed a second-level lookahead unit across 16 groups (4x4 hierarchy).
REQ-016 Group carry-ins SHALL come only from the lookahead unit; the carry into bit 0 SHALL equal operation.
REQ-017 Overflow SHALL NOT be flagged; wrap-around is modulo 2^64 on sum, with the 65th bit on carry only.
REQ-018 Boundary behaviour:
  - A+B = 2^64 SHALL give sum=0, carry=1.
  - 0-0 SHALL give sum=0, carry=1.
  - 0-1 SHALL give sum=all ones, carry=0.
REQ-019 An operation change between cycles SHALL affect only the result of the cycle in which it was sampled; there is no cross-cycle state.
REQ-020 Outputs SHALL be driven only from the stage-2 registers, never combinationally from the inputs.

Reset
REQ-021 When rst=1 at a rising edge, all stage-1 registers, sum and carry SHALL clear to 0 on that edge.
REQ-022 Reset asserted mid-stream SHALL discard any in-flight operation.
REQ-023 After rst deasserts, the first valid result SHALL appear 2 edges after the first sampled input.
REQ-024 Before the first reset, the output value SHALL be unspecified; a bench SHALL apply reset first.

Verification
REQ-025 Subtract: a=0x111, b=0x010, operation=1, held -> after 2 edges, sum=0x0000000000000101, carry=1, stable thereafter.
REQ-026 Add with full carry: a=0xFFFFFFFFFFFFFFFF, b=0x1, operation=0 -> sum=0, carry=1.
REQ-027 Borrow: a=0x0, b=0x1, operation=1 -> sum=0xFFFFFFFFFFFFFFFF, carry=0.
REQ-028 Back-to-back operations:
  - Edge 1: a=5, b=3, operation=0.
  - Edge 2: a=5, b=3, operation=1.
  - Response: sum=8 then sum=2 on consecutive cycles, carry 0 then 1.
REQ-029 Reset mid-stream: rst=1 for one edge while operations are in flight -> sum=0, carry=0 on the next edge, then correct results resume with 2-edge latency.
REQ-030 Random: 10k random a, b, operation values SHALL be checked against a 65-bit reference model with 2-cycle delay; zero mismatches are required.
